// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-path constants, used by the fetch-issue stage and the
// instruction fetch buffer.
package instruction_fetch_pkg;

    localparam int          INSTRUCTION_WIDTH = 32;
    localparam logic [31:0] RESET_PC          = 32'h1000_0000;
    localparam logic [31:0] PC_STEP           = 32'd4;

    // Sequential fetch: every instruction word advances the PC by one word.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/instruction_fetch_buffer_if.sv
// Handshake bundle between fetch-issue/bus, decode and the fetch buffer.
// slave  : the fetch buffer side.
// master : the surrounding pipeline (issue stage, bus return, decode).
interface instruction_fetch_buffer_if;
    import instruction_fetch_pkg::*;

    logic                         issue_enable;
    logic                         issue_ready;
    logic [INSTRUCTION_WIDTH-1:0] system_bus_read_data;
    logic                         system_bus_read_data_valid;
    logic                         flush;
    logic [31:0]                  flush_pc;
    logic                         instruction_valid;
    logic                         instruction_ready;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
    logic [31:0]                  instruction_pc;

    modport slave (
        output issue_enable,
        output instruction_valid,
        output instruction,
        output instruction_pc,
        input  issue_ready,
        input  system_bus_read_data,
        input  system_bus_read_data_valid,
        input  flush,
        input  flush_pc,
        input  instruction_ready
    );

    modport master (
        input  issue_enable,
        input  instruction_valid,
        input  instruction,
        input  instruction_pc,
        output issue_ready,
        output system_bus_read_data,
        output system_bus_read_data_valid,
        output flush,
        output flush_pc,
        output instruction_ready
    );

endinterface

// File: rtl/instruction_fetch_buffer_sync_fifo.sv
// Synchronous FIFO used as the fetch buffer storage. DEPTH must be a power
// of two; pointers carry one extra wrap bit so full and empty are distinct.
// Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer update; low bits wrap modulo DEPTH, clear empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage write; contents need no reset because empty gates the output.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/instruction_fetch_buffer.sv
// Instruction fetch buffer: credit-based issue control, in-order return
// buffering and flush handling with discard of stale bus returns.
// Optional PC tagging is enabled by defining INSTRUCTION_FETCH_BUFFER_PC_TAG_EN.
module instruction_fetch_buffer
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic                     clk,
    input logic                     reset,
    instruction_fetch_buffer_if.slave ifb
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  ONE     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW:0]    DEPTH_C = (CW+1)'(DEPTH);
`ifdef INSTRUCTION_FETCH_BUFFER_PC_TAG_EN
    localparam int             ENTRY_W = 2 * INSTRUCTION_WIDTH;
`else
    localparam int             ENTRY_W = INSTRUCTION_WIDTH;
`endif

    logic [CW-1:0]      count, count_nxt;
    logic [CW-1:0]      outstanding, outstanding_nxt;
    logic [CW-1:0]      discard, discard_nxt;
    logic [CW:0]        credit_used;
    logic               issue;
    logic               ret;
    logic               ret_legal;
    logic               ret_discarded;
    logic               ret_accept;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

    // Every entry, in-flight read and pending discard holds one credit.
    assign credit_used   = {1'b0, count} + {1'b0, outstanding} + {1'b0, discard};
    assign ifb.issue_enable = !ifb.flush && (credit_used < DEPTH_C);
    assign issue         = ifb.issue_enable && ifb.issue_ready;

    assign ret           = ifb.system_bus_read_data_valid;
    assign ret_legal     = ret && ((discard != '0) || (outstanding != '0));
    assign ret_discarded = ret && (discard != '0);
    assign ret_accept    = ret && (discard == '0) && (outstanding != '0) && !ifb.flush;
    assign push          = ret_accept && !fifo_full;
    assign pop           = ifb.instruction_valid && ifb.instruction_ready && !ifb.flush;

    // Counter next-state; a flush turns every in-flight read into a discard,
    // minus the one return consumed in the flush cycle itself.
    always_comb begin
        count_nxt       = count;
        outstanding_nxt = outstanding;
        discard_nxt     = discard;
        if (ifb.flush) begin
            count_nxt       = '0;
            outstanding_nxt = '0;
            discard_nxt     = discard + outstanding;
            if (ret_legal) discard_nxt = discard_nxt - ONE;
        end else begin
            if (push && !pop)      count_nxt = count + ONE;
            else if (pop && !push) count_nxt = count - ONE;
            if (issue && !ret_accept)      outstanding_nxt = outstanding + ONE;
            else if (!issue && ret_accept) outstanding_nxt = outstanding - ONE;
            if (ret_discarded) discard_nxt = discard - ONE;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            count       <= count_nxt;
            outstanding <= outstanding_nxt;
            discard     <= discard_nxt;
        end
    end

`ifdef INSTRUCTION_FETCH_BUFFER_PC_TAG_EN
    logic [31:0] pc_tag;

    // PC of the next word to enter the buffer; redirected by flush.
    always_ff @(posedge clk) begin
        if (reset)          pc_tag <= RESET_PC;
        else if (ifb.flush) pc_tag <= ifb.flush_pc;
        else if (push)      pc_tag <= next_pc(pc_tag);
    end

    assign push_entry         = {pc_tag, ifb.system_bus_read_data};
    assign ifb.instruction_pc = ifb.instruction_valid ?
                                head_entry[ENTRY_W-1:INSTRUCTION_WIDTH] : 32'd0;
`else
    logic unused_flush_pc;

    assign unused_flush_pc    = ^ifb.flush_pc;
    assign push_entry         = ifb.system_bus_read_data;
    assign ifb.instruction_pc = 32'd0;
`endif

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (ifb.flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ifb.instruction_valid = !fifo_empty;
    assign ifb.instruction       = ifb.instruction_valid ?
                                   head_entry[INSTRUCTION_WIDTH-1:0] : '0;

`ifndef SYNTHESIS
    // A return with nothing in flight breaks the bus protocol; it is ignored above.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(ret && !ret_legal))
                else $error("instruction_fetch_buffer: read return with no read in flight");
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Directed testbench for instruction_fetch_buffer (DEPTH = 4).
module tb_instruction_fetch_buffer;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    instruction_fetch_buffer_if bus ();

    instruction_fetch_buffer #(
        .DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ifb   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
            else begin
                n_fail++;
                $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
            end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_pc(input logic [31:0] pc);
`ifdef INSTRUCTION_FETCH_BUFFER_PC_TAG_EN
        return pc;
`else
        return 32'd0;
`endif
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset                          = 1'b1;
        bus.issue_ready                = 1'b0;
        bus.system_bus_read_data       = 32'd0;
        bus.system_bus_read_data_valid = 1'b0;
        bus.flush                      = 1'b0;
        bus.flush_pc                   = 32'd0;
        bus.instruction_ready          = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_valid", 32'(bus.instruction_valid), 32'd0);
        check("rst_instr", bus.instruction, 32'd0);
        check("rst_pc", bus.instruction_pc, 32'd0);
        check("rst_issue_en", 32'(bus.issue_enable), 32'd1);
        check("rst_count", 32'(dut.count), 32'd0);

        // Four issues, then in-order returns with decode always ready
        bus.issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) cyc();
        check("a_issue_en_full", 32'(bus.issue_enable), 32'd0);
        check("a_outstanding", 32'(dut.outstanding), 32'd4);
        bus.issue_ready       = 1'b0;
        bus.instruction_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.system_bus_read_data       = 32'h13 + 32'(k);
            bus.system_bus_read_data_valid = 1'b1;
            cyc();
            bus.system_bus_read_data_valid = 1'b0;
            #1;
            check("a_valid", 32'(bus.instruction_valid), 32'd1);
            check("a_instr", bus.instruction, 32'h13 + 32'(k));
            check("a_pc", bus.instruction_pc, exp_pc(32'h1000_0000 + 32'(4 * k)));
            check("a_count", 32'(dut.count), 32'd1);
        end
        cyc();
        check("a_drained", 32'(bus.instruction_valid), 32'd0);
        check("a_issue_en_back", 32'(bus.issue_enable), 32'd1);

        // Decode stalled: credit stops issue at four
        bus.instruction_ready = 1'b0;
        bus.issue_ready       = 1'b1;
        for (int k = 0; k < 4; k++) cyc();
        check("b_issue_en", 32'(bus.issue_enable), 32'd0);
        cyc();
        cyc();
        check("b_no_fifth", 32'(dut.outstanding), 32'd4);
        for (int k = 0; k < 4; k++) begin
            bus.system_bus_read_data       = 32'hA0 + 32'(k);
            bus.system_bus_read_data_valid = 1'b1;
            cyc();
            check("b_issue_en_ret", 32'(bus.issue_enable), 32'd0);
            check("b_count", 32'(dut.count), 32'(k + 1));
        end
        bus.system_bus_read_data_valid = 1'b0;
        #1;
        check("b_full_head", bus.instruction, 32'hA0);

        // Pop to count 3, issue one, then push and pop together at count 3
        bus.issue_ready       = 1'b0;
        bus.instruction_ready = 1'b1;
        cyc();
        bus.instruction_ready = 1'b0;
        #1;
        check("c_count3", 32'(dut.count), 32'd3);
        check("c_head_a1", bus.instruction, 32'hA1);
        bus.issue_ready = 1'b1;
        cyc();
        bus.issue_ready = 1'b0;
        #1;
        check("c_issue_en_full", 32'(bus.issue_enable), 32'd0);
        bus.system_bus_read_data       = 32'hA4;
        bus.system_bus_read_data_valid = 1'b1;
        bus.instruction_ready          = 1'b1;
        cyc();
        bus.system_bus_read_data_valid = 1'b0;
        #1;
        check("c_count_same", 32'(dut.count), 32'd3);
        check("c_head_a2", bus.instruction, 32'hA2);
        check("c_pc_a2", bus.instruction_pc, exp_pc(32'h1000_0018));
        cyc();
        check("c_head_a3", bus.instruction, 32'hA3);
        check("c_pc_a3", bus.instruction_pc, exp_pc(32'h1000_001C));
        cyc();
        check("c_head_a4", bus.instruction, 32'hA4);
        check("c_pc_a4", bus.instruction_pc, exp_pc(32'h1000_0020));
        cyc();
        check("c_empty", 32'(bus.instruction_valid), 32'd0);

        // Flush with three reads in flight
        bus.issue_ready = 1'b1;
        for (int k = 0; k < 3; k++) cyc();
        bus.issue_ready = 1'b0;
        #1;
        check("d_outstanding", 32'(dut.outstanding), 32'd3);
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h2000_0000;
        #1;
        check("d_issue_en_flush", 32'(bus.issue_enable), 32'd0);
        cyc();
        bus.flush = 1'b0;
        #1;
        check("d_discard", 32'(dut.discard), 32'd3);
        check("d_out_cleared", 32'(dut.outstanding), 32'd0);
        bus.issue_ready = 1'b1;
        cyc();
        bus.issue_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.system_bus_read_data       = 32'hDEAD_0000 + 32'(k);
            bus.system_bus_read_data_valid = 1'b1;
            cyc();
            check("d_dropped", 32'(bus.instruction_valid), 32'd0);
        end
        bus.system_bus_read_data       = 32'h33;
        bus.system_bus_read_data_valid = 1'b1;
        cyc();
        bus.system_bus_read_data_valid = 1'b0;
        #1;
        check("d_new_valid", 32'(bus.instruction_valid), 32'd1);
        check("d_new_instr", bus.instruction, 32'h33);
        check("d_new_pc", bus.instruction_pc, exp_pc(32'h2000_0000));
        cyc();
        check("d_after_pop", 32'(bus.instruction_valid), 32'd0);

        // Return coincident with flush, two reads in flight
        bus.issue_ready = 1'b1;
        cyc();
        cyc();
        bus.issue_ready                = 1'b0;
        bus.flush                      = 1'b1;
        bus.system_bus_read_data       = 32'h0000_0BAD;
        bus.system_bus_read_data_valid = 1'b1;
        cyc();
        bus.flush                      = 1'b0;
        bus.system_bus_read_data_valid = 1'b0;
        #1;
        check("e_discard", 32'(dut.discard), 32'd1);
        check("e_valid", 32'(bus.instruction_valid), 32'd0);
        bus.system_bus_read_data       = 32'h0000_0BAE;
        bus.system_bus_read_data_valid = 1'b1;
        cyc();
        bus.system_bus_read_data_valid = 1'b0;
        #1;
        check("e_discard_done", 32'(dut.discard), 32'd0);
        check("e_count", 32'(dut.count), 32'd0);

        // Reset with one buffered entry and two reads in flight
        bus.instruction_ready = 1'b0;
        bus.issue_ready       = 1'b1;
        for (int k = 0; k < 3; k++) cyc();
        bus.issue_ready                = 1'b0;
        bus.system_bus_read_data       = 32'h77;
        bus.system_bus_read_data_valid = 1'b1;
        cyc();
        bus.system_bus_read_data_valid = 1'b0;
        #1;
        check("f_pre_valid", 32'(bus.instruction_valid), 32'd1);
        check("f_pre_out", 32'(dut.outstanding), 32'd2);
        reset                          = 1'b1;
        bus.flush                      = 1'b1;
        bus.system_bus_read_data       = 32'h0000_BEEF;
        bus.system_bus_read_data_valid = 1'b1;
        bus.instruction_ready          = 1'b1;
        bus.issue_ready                = 1'b1;
        cyc();
        reset                          = 1'b0;
        bus.flush                      = 1'b0;
        bus.system_bus_read_data_valid = 1'b0;
        bus.instruction_ready          = 1'b0;
        bus.issue_ready                = 1'b0;
        #1;
        check("f_valid", 32'(bus.instruction_valid), 32'd0);
        check("f_instr", bus.instruction, 32'd0);
        check("f_pc", bus.instruction_pc, 32'd0);
        check("f_issue_en", 32'(bus.issue_enable), 32'd1);
        check("f_count", 32'(dut.count), 32'd0);
        check("f_outstanding", 32'(dut.outstanding), 32'd0);
        check("f_discard", 32'(dut.discard), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_buffer.md
INSTRUCTION_FETCH_BUFFER -- requirements
Module: instruction_fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entry count and maximum in-flight credit (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port issue_enable  output  1  permission to the fetch-issue stage to issue one bus read.
REQ-005 SHALL have port issue_ready  input  1  fetch-issue/bus ready; issue occurs when issue_enable && issue_ready.
REQ-006 SHALL have port system_bus_read_data  input  32  returned instruction word.
REQ-007 SHALL have port system_bus_read_data_valid  input  1  one read return this cycle, in issue order.
REQ-008 SHALL have port flush  input  1  discard all buffered and in-flight instructions.
REQ-009 SHALL have port flush_pc  input  32  PC of the first fetch after flush.
REQ-010 SHALL have port instruction_valid  output  1  head entry valid to decode.
REQ-011 SHALL have port instruction_ready  input  1  decode accepts head when instruction_valid && instruction_ready.
REQ-012 SHALL have port instruction  output  32  head instruction word.
REQ-013 SHALL have port instruction_pc  output  32  PC of head instruction.

Function
REQ-014 SHALL keep counters count (FIFO occupancy), outstanding (issued, not returned), discard (returns to drop), each ceil(log2(DEPTH))+1 bits wide.
REQ-015 SHALL drive issue_enable = !flush && (count + outstanding + discard < DEPTH), combinationally.
REQ-016 SHALL increment outstanding on issue, decrement on a non-discarded return; both in one cycle leaves it unchanged.
REQ-017 SHALL, while discard > 0, drop each return and decrement discard; such returns never enter the FIFO or decrement outstanding.
REQ-018 SHALL write system_bus_read_data into FIFO tail on a non-discarded return; instruction_valid rises the following cycle (latency 1, no bypass).
REQ-019 SHALL pop head on accept; simultaneous push and pop leaves count unchanged, including at count==DEPTH-1 and count==1.
REQ-020 SHALL never overflow: credit rule guarantees a return always finds a free entry.
REQ-021 SHALL on flush, next cycle: count=0, instruction_valid=0, discard = discard + outstanding - (1 if a discarded return arrives this cycle), outstanding=0; any return in the flush cycle is dropped; flush overrides push and pop.
REQ-022 SHALL treat a return with outstanding==0 and discard==0 as a protocol violation, flagged by a simulation assertion, and ignore it.
REQ-023 SHALL wrap FIFO read/write pointers modulo DEPTH.

Reset
REQ-024 SHALL on reset clear count, outstanding, discard, pointers; instruction_valid=0, issue_enable=1 from the first post-reset cycle, instruction=0.
REQ-025 SHALL let reset override flush and all in-flight events; returns arriving the reset cycle are dropped.

Configuration
REQ-026 SHALL, with INSTRUCTION_FETCH_BUFFER_PC_TAG_EN defined, hold a PC tag register (reset 32'h10000000, +4 per FIFO push, loaded from flush_pc on flush) and store the tag per entry, driving instruction_pc from head.
REQ-027 SHALL, without INSTRUCTION_FETCH_BUFFER_PC_TAG_EN, omit tag storage, tie instruction_pc to 0, and ignore flush_pc.

Structure
REQ-028 SHALL take RESET_PC (32'h10000000) and INSTRUCTION_WIDTH (32) from shared package instruction_fetch_pkg, also used by the fetch-issue stage.
REQ-029 SHALL instantiate one sub-module sync_fifo (parameterised width/depth, push/pop/full/empty) for storage; counters and credit logic stay in the top.

Verification
REQ-030 SHALL cover: reset, 4 issues, returns 0x00000013..0x00000016 with ready=1 -> instructions in order, PCs 0x10000000..0x1000000C, each one cycle after return.
REQ-031 SHALL cover: instruction_ready=0, DEPTH=4 -> issue_enable drops after 4 issues, no 5th issue, count never exceeds 4.
REQ-032 SHALL cover: 3 outstanding, flush with flush_pc=0x20000000 -> next 3 returns dropped, following return appears with PC 0x20000000.
REQ-033 SHALL cover: simultaneous push and pop at count 1 and 3 -> count unchanged, data order preserved.
REQ-034 SHALL cover: return coincident with flush, and reset asserted with 2 outstanding -> returns dropped, all outputs at reset values next cycle.
